des_key_schedule: RTL

Sequential DES key-schedule controller that turns one 64-bit key into the sixteen 48-bit round subkeys, one subkey per handshake. It owns the C/D half-key registers and the round counter, and sequences the existing combinational PC1, per-round rotation and PC2 stages. It produces subkeys in encrypt order (K1..K16) or decrypt order (K16..K1), and sits between the key-load interface and the round datapath.

---
 rtl/des_pkg.sv | 34 +++
 rtl/des_key_schedule_if.sv | 27 ++
 rtl/des_cd_rotate.sv | 25 ++
 rtl/des_pc1.sv | 27 ++
 rtl/des_pc2.sv | 26 ++
 rtl/des_key_schedule.sv | 104 ++++++++++
 6 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES key-schedule controller.
// Vectors follow DES numbering: bit 1 is the MSB of every [1:N] range.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_e;

    // Left-rotation amount applied before round r (r = 1..16).
    localparam logic [1:0] SHIFT_SCHED [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Out-of-range rounds yield no rotation.
    function automatic logic [1:0] shift_of(input logic [4:0] round);
        shift_of = 2'd0;
        if (round >= 5'd1 && round <= 5'd16) begin
            shift_of = SHIFT_SCHED[round];
        end
    endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-load and subkey-delivery bus between key source, schedule and round datapath.
interface des_key_schedule_if;
    import des_pkg::*;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // once valid is raised the payload holds until that transfer edge.
    logic [1:KEY_W]    key;
    logic              decrypt;
    logic              key_valid;
    logic              key_ready;
    logic [1:SUBKEY_W] subkey;
    logic [3:0]        subkey_round;
    logic              subkey_last;
    logic              subkey_valid;
    logic              subkey_ready;

    modport slave (
        input  key, decrypt, key_valid, subkey_ready,
        output key_ready, subkey, subkey_round, subkey_last, subkey_valid
    );

    modport master (
        output key, decrypt, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_round, subkey_last, subkey_valid
    );

endinterface

// File: rtl/des_cd_rotate.sv
// Rotates the C and D halves independently by 0, 1 or 2 bits, left or right.
module des_cd_rotate
    import des_pkg::*;
(
    input  logic [1:56] cd_i,
    input  logic [1:0]  amount_i,
    input  rot_dir_e    dir_i,
    output logic [1:56] cd_o
);

    function automatic logic [1:28] rot_half(input logic [1:28] h,
                                             input logic [1:0]  n,
                                             input rot_dir_e    d);
        rot_half = h;
        case (n)
            2'd1:    rot_half = (d == ROT_LEFT) ? {h[2:28], h[1]}    : {h[28], h[1:27]};
            2'd2:    rot_half = (d == ROT_LEFT) ? {h[3:28], h[1:2]}  : {h[27:28], h[1:26]};
            default: rot_half = h;
        endcase
    endfunction

    assign cd_o = {rot_half(cd_i[1:28],  amount_i, dir_i),
                   rot_half(cd_i[29:56], amount_i, dir_i)};

endmodule

// File: rtl/des_pc1.sv
// Permuted Choice 1: selects the 56 key bits forming C0 (1..28) and D0 (29..56).
module des_pc1 (
    input  logic [1:64] key_i,
    output logic [1:56] cd_o
);

    localparam int PC1_TBL [1:56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    for (genvar i = 1; i <= 56; i++) begin : g_pc1
        assign cd_o[i] = key_i[PC1_TBL[i]];
    end

    // Parity bits never reach the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                             key_i[40], key_i[48], key_i[56], key_i[64]};

endmodule

// File: rtl/des_pc2.sv
// Permuted Choice 2: compresses a 56-bit CD state into a 48-bit round subkey.
module des_pc2 (
    input  logic [1:56] cd_i,
    output logic [1:48] subkey_o
);

    localparam int PC2_TBL [1:48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    for (genvar i = 1; i <= 48; i++) begin : g_pc2
        assign subkey_o[i] = cd_i[PC2_TBL[i]];
    end

    logic unused_dropped;
    assign unused_dropped = ^{cd_i[9], cd_i[18], cd_i[22], cd_i[25],
                              cd_i[35], cd_i[38], cd_i[43], cd_i[54]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key-schedule controller: takes one key, then issues the sixteen round
// subkeys one per handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    des_key_schedule_if.slave   bus,
    output state_e              dbg_state
);

    state_e              state_q, state_d;
    logic [1:CD_W]       cd_q, cd_d;
    logic [3:0]          step_q, step_d;
    logic                mode_q, mode_d;
    logic [1:SUBKEY_W]   subkey_q, subkey_d;
    logic                load;

    logic [1:CD_W]       pc1_cd;
    logic [1:CD_W]       accept_cd;
    logic [1:CD_W]       rot_cd;
    logic [1:SUBKEY_W]   pc2_subkey;
    logic [4:0]          sched_round;

    des_pc1 u_pc1 (.key_i(bus.key), .cd_o(pc1_cd));

    // Encrypt starts from C1D1; decrypt starts from C0D0, which equals C16D16.
    assign accept_cd = bus.decrypt ? pc1_cd
                                   : {pc1_cd[2:28], pc1_cd[1], pc1_cd[30:56], pc1_cd[29]};

    // Encrypt moves forward by the next round's shift; decrypt undoes the current round's.
    assign sched_round = mode_q ? (5'd16 - {1'b0, step_q}) : ({1'b0, step_q} + 5'd2);

    des_cd_rotate u_rotate (
        .cd_i     (cd_q),
        .amount_i (shift_of(sched_round)),
        .dir_i    (mode_q ? ROT_RIGHT : ROT_LEFT),
        .cd_o     (rot_cd)
    );

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        step_d  = step_q;
        mode_d  = mode_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = RUN;
                    mode_d  = bus.decrypt;
                    cd_d    = accept_cd;
                    step_d  = 4'd0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (bus.subkey_ready) begin
                    if (step_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        step_d = step_q + 4'd1;
                        cd_d   = rot_cd;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    des_pc2 u_pc2 (.cd_i(cd_d), .subkey_o(pc2_subkey));

    always_comb begin
        subkey_d = subkey_q;
        if (load) begin
            subkey_d = pc2_subkey;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cd_q     <= '0;
            step_q   <= 4'd0;
            mode_q   <= 1'b0;
            subkey_q <= '0;
        end else begin
            state_q  <= state_d;
            cd_q     <= cd_d;
            step_q   <= step_d;
            mode_q   <= mode_d;
            subkey_q <= subkey_d;
        end
    end

    assign bus.key_ready    = (state_q == IDLE);
    assign bus.subkey_valid = (state_q == RUN);
    assign bus.subkey_last  = (state_q == RUN) && (step_q == 4'd15);
    assign bus.subkey_round = mode_q ? (4'd15 - step_q) : step_q;
    assign bus.subkey       = subkey_q;
    assign dbg_state        = state_q;

endmodule
